// File: rtl/uart_io_pkg.sv
// Shared constants for the UART device controller: register map, status/ctrl bits, FSM states.
package uart_io_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_DIV  = 2'd2;

    localparam int unsigned ST_RX_VALID  = 0;
    localparam int unsigned ST_RX_FULL   = 1;
    localparam int unsigned ST_TX_FULL   = 2;
    localparam int unsigned ST_TX_EMPTY  = 3;
    localparam int unsigned ST_TX_BUSY   = 4;
    localparam int unsigned ST_RX_OVR    = 5;
    localparam int unsigned ST_FRAME_ERR = 6;
    localparam int unsigned ST_TX_OVF    = 7;

    localparam int unsigned CTRL_POP = 0;
    localparam int unsigned CTRL_CLR = 1;

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem_q[rptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            if (do_push != do_pop) begin
                count_q <= do_push ? count_q + (AW+1)'(1) : count_q - (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_io_ctrl.sv
// Memory-mapped UART controller: bus register file, TX/RX FIFOs, TX and RX serial FSMs.
module uart_io_ctrl import uart_io_pkg::*; #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned DIV_RESET  = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  reg_sel,
    input  logic        cs,
    input  logic [15:0] in,
    output logic [15:0] out,
    input  logic        rx,
    output logic        tx
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = $clog2(DATA_BITS);

    logic acc_q, access, wr_data, wr_stat, wr_div, cpu_pop, cpu_clr;
    logic [DIV_W-1:0] div_q;

    assign access  = cs & we & ~acc_q;
    assign wr_data = access & (reg_sel == REG_DATA);
    assign wr_stat = access & (reg_sel == REG_STAT);
    assign wr_div  = access & (reg_sel == REG_DIV);
    assign cpu_pop = wr_stat & in[CTRL_POP];
    assign cpu_clr = wr_stat & in[CTRL_CLR];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= 1'b0;
            div_q <= DIV_W'(DIV_RESET);
        end else begin
            acc_q <= cs & we;
            if (wr_div) div_q <= (in[DIV_W-1:0] < DIV_W'(2)) ? DIV_W'(2) : in[DIV_W-1:0];
        end
    end

    logic [DATA_BITS-1:0] tx_head, rx_head;
    logic                 tx_full, tx_empty, rx_full, rx_empty, tx_pop, rx_push;
    logic [CW-1:0]        tx_count, rx_count;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(wr_data), .pop(tx_pop), .wdata(in[DATA_BITS-1:0]),
        .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(cpu_pop), .wdata(rx_sh_q),
        .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // TX FSM: each bit length is taken from div_q when the bit starts.
    tx_state_e            tx_state_q, tx_state_d;
    logic [DIV_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [BW-1:0]        tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_pop     = 1'b0;
        tx         = 1'b1;
        unique case (tx_state_q)
            TxIdle: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_head;
                    tx_cnt_d   = div_q - DIV_W'(1);
                    tx_state_d = TxStart;
                end
            end
            TxStart: begin
                tx = 1'b0;
                if (tx_cnt_q == '0) begin
                    tx_cnt_d   = div_q - DIV_W'(1);
                    tx_bit_d   = '0;
                    tx_state_d = TxData;
                end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
            end
            TxData: begin
                tx = tx_sh_q[0];
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = div_q - DIV_W'(1);
                    tx_sh_d  = tx_sh_q >> 1;
                    if (tx_bit_q == BW'(DATA_BITS - 1)) tx_state_d = TxStop;
                    else tx_bit_d = tx_bit_q + BW'(1);
                end else tx_cnt_d = tx_cnt_q - DIV_W'(1);
            end
            TxStop: begin
                if (tx_cnt_q == '0) tx_state_d = TxIdle;
                else tx_cnt_d = tx_cnt_q - DIV_W'(1);
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    // RX: 2-FF synchroniser plus one more stage for falling-edge detection.
    logic rx_s1_q, rx_s2_q, rx_s3_q, rx_fall, frame_set;
    rx_state_e        rx_state_q, rx_state_d;
    logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [BW-1:0]    rx_bit_q, rx_bit_d;

    assign rx_fall = rx_s3_q & ~rx_s2_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        frame_set  = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_fall) begin
                    rx_cnt_d   = (div_q >> 1) - DIV_W'(1);
                    rx_state_d = RxStart;
                end
            end
            RxStart: begin
                if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - DIV_W'(1);
                else if (rx_s2_q) rx_state_d = RxIdle;
                else begin
                    rx_cnt_d   = div_q - DIV_W'(1);
                    rx_bit_d   = '0;
                    rx_state_d = RxData;
                end
            end
            RxData: begin
                if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - DIV_W'(1);
                else begin
                    rx_cnt_d = div_q - DIV_W'(1);
                    rx_sh_d  = {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BW'(DATA_BITS - 1)) rx_state_d = RxStop;
                    else rx_bit_d = rx_bit_q + BW'(1);
                end
            end
            RxStop: begin
                if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - DIV_W'(1);
                else begin
                    rx_push    = rx_s2_q;
                    frame_set  = ~rx_s2_q;
                    rx_state_d = RxIdle;
                end
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    logic tx_ovf_q, rx_ovr_q, frame_err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q  <= TxIdle;
            tx_cnt_q    <= '0;
            tx_bit_q    <= '0;
            tx_sh_q     <= '0;
            rx_state_q  <= RxIdle;
            rx_cnt_q    <= '0;
            rx_bit_q    <= '0;
            rx_sh_q     <= '0;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_s3_q     <= 1'b1;
            tx_ovf_q    <= 1'b0;
            rx_ovr_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_bit_q    <= tx_bit_d;
            tx_sh_q     <= tx_sh_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_bit_q    <= rx_bit_d;
            rx_sh_q     <= rx_sh_d;
            rx_s1_q     <= rx;
            rx_s2_q     <= rx_s1_q;
            rx_s3_q     <= rx_s2_q;
            // New error events win over a simultaneous clear.
            tx_ovf_q    <= (tx_ovf_q & ~cpu_clr) | (wr_data & tx_full & ~tx_pop);
            rx_ovr_q    <= (rx_ovr_q & ~cpu_clr) | (rx_push & rx_full & ~(cpu_pop & ~rx_empty));
            frame_err_q <= (frame_err_q & ~cpu_clr) | frame_set;
        end
    end

    logic [7:0] status;
    logic       unused_sig;

    assign unused_sig = ^{tx_count, rx_count, in};

    always_comb begin
        status               = '0;
        status[ST_RX_VALID]  = ~rx_empty;
        status[ST_RX_FULL]   = rx_full;
        status[ST_TX_FULL]   = tx_full;
        status[ST_TX_EMPTY]  = tx_empty;
        status[ST_TX_BUSY]   = (tx_state_q != TxIdle);
        status[ST_RX_OVR]    = rx_ovr_q;
        status[ST_FRAME_ERR] = frame_err_q;
        status[ST_TX_OVF]    = tx_ovf_q;
        out = '0;
        if (cs) begin
            case (reg_sel)
                REG_DATA: if (!rx_empty) out = 16'(rx_head);
                REG_STAT: out = 16'(status);
                REG_DIV:  out = 16'(div_q);
                default:  out = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Self-checking bench for uart_io_ctrl: a TX line decoder scoreboards transmitted bytes,
// and an RX queue scoreboards bytes driven onto rx.
module tb_uart_io_ctrl;
    import uart_io_pkg::*;

    logic        clk = 1'b0;
    logic        reset, we, cs, rx, tx, loop, rx_drv, mon_en;
    logic [1:0]  reg_sel;
    logic [15:0] in_d, out_d;
    int          vectors = 0, miscompares = 0, frames_seen = 0, mon_div = 4;
    logic [7:0]  tx_exp[$];
    logic [7:0]  rx_exp[$];

    always #5 clk = ~clk;
    assign rx = loop ? tx : rx_drv;

    uart_io_ctrl dut (
        .clk(clk), .reset(reset), .we(we), .reg_sel(reg_sel), .cs(cs),
        .in(in_d), .out(out_d), .rx(rx), .tx(tx)
    );

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Decodes frames on tx at mon_div clocks per bit and checks them against tx_exp.
    initial begin : tx_monitor
        logic       prev, ok;
        logic [7:0] b, e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !tx) begin
                ok = 1'b1;
                repeat (mon_div / 2) @(negedge clk);
                if (tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_div) @(negedge clk);
                    b[i] = tx;
                end
                repeat (mon_div) @(negedge clk);
                if (tx !== 1'b1) ok = 1'b0;
                if (mon_en) begin
                    frames_seen++;
                    vectors++;
                    if (tx_exp.size() == 0) begin
                        miscompares++;
                        $display("FAIL tx_frame: got byte %h, no frame expected", b);
                    end else begin
                        e = tx_exp.pop_front();
                        if (!ok || b !== e) begin
                            miscompares++;
                            $display("FAIL tx_frame: got byte %h framing_ok=%0d, want %h", b, ok, e);
                        end
                    end
                end
            end
            prev = tx;
        end
    end

    task automatic bus_write(input logic [1:0] r, input logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b1; reg_sel = r; in_d = d;
        @(negedge clk);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] r, output logic [15:0] d);
        @(negedge clk);
        cs = 1'b1; we = 1'b0; reg_sel = r;
        #1 d = out_d;
        cs = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (4) @(negedge clk);
        end
        rx_drv = stop;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [15:0] r;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx); end
        bus_read(REG_STAT, r);
        vectors++;
        if (r !== 16'h0008) begin miscompares++; $display("FAIL reset_stat: got %h want 0008", r); end
        bus_read(REG_DIV, r);
        vectors++;
        if (r !== 16'd868) begin miscompares++; $display("FAIL reset_div: got %0d want 868", r); end
        bus_read(REG_DATA, r);
        vectors++;
        if (r !== 16'h0000) begin miscompares++; $display("FAIL reset_data: got %h want 0000", r); end
        @(negedge clk);
        cs = 1'b0; reg_sel = REG_DIV;
        #1 vectors++;
        if (out_d !== 16'h0000) begin miscompares++; $display("FAIL cs_low_out: got %h want 0000", out_d); end
    endtask

    task automatic test_div();
        logic [15:0] r;
        bus_write(REG_DIV, 16'd1);
        bus_read(REG_DIV, r);
        vectors++;
        if (r !== 16'd2) begin miscompares++; $display("FAIL div_min: got %0d want 2", r); end
        bus_write(REG_DIV, 16'd4);
        bus_write(2'd3, 16'hFFFF);
        bus_read(REG_DIV, r);
        vectors++;
        if (r !== 16'd4) begin miscompares++; $display("FAIL div_set: got %0d want 4", r); end
        bus_read(2'd3, r);
        vectors++;
        if (r !== 16'h0000) begin miscompares++; $display("FAIL reg3_read: got %h want 0000", r); end
    endtask

    task automatic test_tx_frame();
        logic [7:0] byte_v;
        logic [9:0] fb;
        int         n;
        byte_v = 8'hA5;
        fb = {1'b1, byte_v, 1'b0};
        mon_div = 4;
        mon_en = 1'b1;
        tx_exp.push_back(byte_v);
        bus_write(REG_DATA, {8'h00, byte_v});
        cs = 1'b1; we = 1'b0; reg_sel = REG_STAT;
        n = 0;
        while (tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (n >= 20) begin miscompares++; $display("FAIL tx_start: tx=%b, want 0 within 20 clocks", tx); end
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (tx !== fb[b]) begin
                    miscompares++;
                    $display("FAIL tx_bit%0d_clk%0d: got %b want %b", b, k, tx, fb[b]);
                end
                if (k == 2) begin
                    vectors++;
                    if (out_d[ST_TX_BUSY] !== 1'b1) begin
                        miscompares++; $display("FAIL tx_busy_during: got %b want 1", out_d[ST_TX_BUSY]);
                    end
                end
                @(negedge clk);
            end
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (out_d[4:3] !== 2'b01) begin
            miscompares++; $display("FAIL tx_done_stat: got busy,empty=%b want 01", out_d[4:3]);
        end
        cs = 1'b0;
    endtask

    task automatic test_loopback();
        logic [15:0] r;
        int          n;
        loop = 1'b1;
        tx_exp.push_back(8'h3C);
        rx_exp.push_back(8'h3C);
        bus_write(REG_DATA, 16'h003C);
        n = 0;
        r = '0;
        while (r[ST_RX_VALID] !== 1'b1 && n < 200) begin bus_read(REG_STAT, r); n++; end
        vectors++;
        if (r[ST_RX_VALID] !== 1'b1) begin miscompares++; $display("FAIL loop_valid: got %b want 1", r[0]); end
        bus_read(REG_DATA, r);
        vectors++;
        if (r !== {8'h00, rx_exp[0]}) begin miscompares++; $display("FAIL loop_data: got %h want %h", r, rx_exp[0]); end
        void'(rx_exp.pop_front());
        bus_write(REG_STAT, 16'h0001);
        bus_read(REG_STAT, r);
        vectors++;
        if (r[ST_RX_VALID] !== 1'b0) begin miscompares++; $display("FAIL loop_pop: got %b want 0", r[0]); end
        repeat (10) @(negedge clk);
        loop = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] r;
        int          f0, n;
        repeat (10) @(negedge clk);
        f0 = frames_seen;
        for (int i = 0; i < 18; i++) begin
            if (i < 17) tx_exp.push_back(8'h10 + 8'(i));
            bus_write(REG_DATA, 16'h0010 + 16'(i));
        end
        bus_read(REG_STAT, r);
        vectors++;
        if (r[ST_TX_OVF] !== 1'b1) begin miscompares++; $display("FAIL tx_ovf_set: got %b want 1", r[7]); end
        vectors++;
        if (r[ST_TX_FULL] !== 1'b1) begin miscompares++; $display("FAIL tx_full: got %b want 1", r[2]); end
        n = 0;
        while (tx_exp.size() != 0 && n < 1000) begin @(negedge clk); n++; end
        repeat (100) @(negedge clk);
        vectors++;
        if (frames_seen - f0 != 17) begin
            miscompares++; $display("FAIL tx_frame_count: got %0d want 17", frames_seen - f0);
        end
        bus_write(REG_STAT, 16'h0002);
        bus_read(REG_STAT, r);
        vectors++;
        if (r[ST_TX_OVF] !== 1'b0) begin miscompares++; $display("FAIL tx_ovf_clr: got %b want 0", r[7]); end
    endtask

    task automatic test_frame_err();
        logic [15:0] r;
        send_rx(8'h55, 1'b0);
        repeat (8) @(negedge clk);
        bus_read(REG_STAT, r);
        vectors++;
        if ({r[ST_FRAME_ERR], r[ST_RX_VALID]} !== 2'b10) begin
            miscompares++; $display("FAIL frame_err: got err,valid=%b%b want 10", r[6], r[0]);
        end
        bus_write(REG_STAT, 16'h0002);
        bus_read(REG_STAT, r);
        vectors++;
        if (r[ST_FRAME_ERR] !== 1'b0) begin miscompares++; $display("FAIL frame_err_clr: got %b want 0", r[6]); end
    endtask

    task automatic test_glitch();
        logic [15:0] r;
        @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
        bus_read(REG_STAT, r);
        vectors++;
        if (r[7:0] !== 8'h08) begin miscompares++; $display("FAIL glitch: got stat %h want 08", r); end
    endtask

    task automatic test_rx_overflow();
        logic [15:0] r;
        logic [7:0]  b;
        for (int i = 0; i < 17; i++) begin
            b = 8'h40 + 8'(i * 3);
            if (i < 16) rx_exp.push_back(b);
            send_rx(b, 1'b1);
        end
        repeat (8) @(negedge clk);
        bus_read(REG_STAT, r);
        vectors++;
        if ({r[ST_RX_OVR], r[ST_RX_FULL], r[ST_RX_VALID]} !== 3'b111) begin
            miscompares++; $display("FAIL rx_ovr_full: got ovr,full,valid=%b%b%b want 111", r[5], r[1], r[0]);
        end
        for (int k = 0; k < 2; k++) begin
            bus_read(REG_DATA, r);
            vectors++;
            if (r !== {8'h00, rx_exp[0]}) begin
                miscompares++; $display("FAIL rx_data%0d: got %h want %h", k, r, rx_exp[0]);
            end
            void'(rx_exp.pop_front());
            bus_write(REG_STAT, 16'h0001);
        end
        bus_read(REG_STAT, r);
        vectors++;
        if ({r[ST_RX_OVR], r[ST_RX_FULL]} !== 2'b10) begin
            miscompares++; $display("FAIL rx_after_pop: got ovr,full=%b%b want 10", r[5], r[1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [15:0] r;
        int          n, lows;
        mon_en = 1'b0;
        tx_exp.delete();
        bus_write(REG_DATA, 16'h0000);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        vectors++;
        if (tx !== 1'b0) begin miscompares++; $display("FAIL mid_frame_low: got %b want 0", tx); end
        reset = 1'b1;
        #1 vectors++;
        if (tx !== 1'b1) begin miscompares++; $display("FAIL reset_tx_now: got %b want 1", tx); end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        rx_exp.delete();
        bus_read(REG_STAT, r);
        vectors++;
        if (r !== 16'h0008) begin miscompares++; $display("FAIL reset2_stat: got %h want 0008", r); end
        bus_read(REG_DIV, r);
        vectors++;
        if (r !== 16'd868) begin miscompares++; $display("FAIL reset2_div: got %0d want 868", r); end
        lows = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        vectors++;
        if (lows != 0) begin miscompares++; $display("FAIL reset2_tx_idle: got %0d low clocks want 0", lows); end
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; we = 1'b0; reg_sel = 2'd0; in_d = '0;
        rx_drv = 1'b1; loop = 1'b0; mon_en = 1'b0;
        test_reset();
        test_div();
        test_tx_frame();
        test_loopback();
        test_back_to_back();
        test_frame_err();
        test_glitch();
        test_rx_overflow();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
